// File: rtl/axi_route_pkg.sv
// ----------------------------------------------------------------------------
// axi_route_pkg
//   Shared types and width helpers for the AXI channel router.
//   - route_state_e : burst-lock FSM states (RT_IDLE, RT_LOCK)
//   - sel_w_of()    : select width for a given port count (one extra MSB so
//                     out-of-range decode-error codes can be expressed)
//   - dest_w_of()   : width of an in-range port index
// ----------------------------------------------------------------------------
package axi_route_pkg;

    typedef enum logic {
        RT_IDLE = 1'b0,
        RT_LOCK = 1'b1
    } route_state_e;

    localparam int DEF_NUM_OUT = 4;

    function automatic int sel_w_of(input int num_out);
        return $clog2(num_out) + 1;
    endfunction

    function automatic int dest_w_of(input int num_out);
        return (num_out > 1) ? $clog2(num_out) : 1;
    endfunction

endpackage

// File: rtl/axi_route_slice.sv
// ----------------------------------------------------------------------------
// axi_route_slice
//   One-entry valid/ready output register used by axi_chan_router when the
//   registered output option (AXI_ROUTE_REG_EN) is built. Holds one beat
//   together with its destination port index.
// Ports
//   ACLK, ARESETn         clock / asynchronous active-low reset
//   in_valid/in_ready     upstream side of the register
//   in_dest/data/last     beat destination index and payload
//   out_ready             ready of the port addressed by buf_dest
//   buf_v/dest/data/last  registered beat presented to the ports
// ----------------------------------------------------------------------------
module axi_route_slice #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 2
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              out_ready,
    output logic              buf_v,
    output logic [DEST_W-1:0] buf_dest,
    output logic [DATA_W-1:0] buf_data,
    output logic              buf_last
);

    // Accept whenever the entry is empty or is being drained this cycle,
    // which keeps full throughput while the downstream port is ready.
    assign in_ready = ~buf_v | out_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            buf_v <= 1'b0;
        end else if (in_ready) begin
            buf_v <= in_valid;
        end
    end

    // Payload is qualified by buf_v, so it needs no reset.
    always_ff @(posedge ACLK) begin
        if (in_valid && in_ready) begin
            buf_dest <= in_dest;
            buf_data <= in_data;
            buf_last <= in_last;
        end
    end

endmodule

// File: rtl/axi_chan_router.sv
// ----------------------------------------------------------------------------
// axi_chan_router
//   1-to-NUM_OUT router for one AXI valid/ready channel. The destination is
//   taken from sel_i on the first beat of a burst and locked until the beat
//   carrying s_last, so bursts never split across ports. Selects >= NUM_OUT
//   are sunk (s_ready=1, no port valid) and flagged with a 1-cycle err_o.
//   Ports that are not selected drive valid/data/last = 0.
// Build option
//   AXI_ROUTE_REG_EN : insert a one-entry output register (1-cycle latency).
//                      Undefined: combinational s->m path (0-cycle latency).
// Ports
//   ACLK, ARESETn      clock / asynchronous active-low reset
//   sel_i              destination index, used only while idle
//   s_valid/s_ready    upstream handshake; s_data, s_last upstream beat
//   m_valid/m_ready    per-port handshake; m_data (port k at k*DATA_W), m_last
//   busy_o             route locked mid-burst
//   err_o              registered pulse after each sunk out-of-range beat
// ----------------------------------------------------------------------------
module axi_chan_router
    import axi_route_pkg::*;
#(
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = sel_w_of(NUM_OUT)
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      s_last,
    output logic [NUM_OUT-1:0]        m_valid,
    input  logic [NUM_OUT-1:0]        m_ready,
    output logic [NUM_OUT*DATA_W-1:0] m_data,
    output logic [NUM_OUT-1:0]        m_last,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int               DEST_W     = dest_w_of(NUM_OUT);
    localparam logic [SEL_W-1:0] PORT_LIMIT = SEL_W'(NUM_OUT);

    route_state_e     state_q;
    logic [SEL_W-1:0] route_q;
    logic [SEL_W-1:0] route;
    logic             in_range;
    logic             hs;

    // While idle the select is used directly so single beats cost no cycle.
    assign route    = (state_q == RT_LOCK) ? route_q : sel_i;
    assign in_range = (route < PORT_LIMIT);
    assign hs       = s_valid & s_ready;
    assign busy_o   = (state_q == RT_LOCK);

    // Lock FSM advances on upstream handshakes only.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= RT_IDLE;
            route_q <= '0;
            err_o   <= 1'b0;
        end else begin
            err_o <= hs & ~in_range;
            if (hs) begin
                if (state_q == RT_IDLE) begin
                    if (!s_last) begin
                        state_q <= RT_LOCK;
                        route_q <= sel_i;
                    end
                end else if (s_last) begin
                    state_q <= RT_IDLE;
                end
            end
        end
    end

`ifdef AXI_ROUTE_REG_EN
    logic              slice_in_ready;
    logic              buf_v;
    logic [DEST_W-1:0] buf_dest;
    logic [DATA_W-1:0] buf_data;
    logic              buf_last;
    logic [NUM_OUT-1:0] buf_oh;
    logic              buf_ready;

    // Sunk beats are kept out of the register by gating in_valid.
    axi_route_slice #(
        .DATA_W (DATA_W),
        .DEST_W (DEST_W)
    ) u_slice (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .in_valid  (s_valid & in_range),
        .in_ready  (slice_in_ready),
        .in_dest   (route[DEST_W-1:0]),
        .in_data   (s_data),
        .in_last   (s_last),
        .out_ready (buf_ready),
        .buf_v     (buf_v),
        .buf_dest  (buf_dest),
        .buf_data  (buf_data),
        .buf_last  (buf_last)
    );

    always_comb begin
        buf_oh = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            buf_oh[k] = buf_v && (buf_dest == DEST_W'(k));
        end
    end

    assign buf_ready = |(m_ready & buf_oh);
    assign s_ready   = ARESETn & (in_range ? slice_in_ready : 1'b1);

    always_comb begin
        m_valid = '0;
        m_data  = '0;
        m_last  = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            m_valid[k] = buf_oh[k];
            if (buf_oh[k]) begin
                m_data[k*DATA_W +: DATA_W] = buf_data;
                m_last[k]                  = buf_last;
            end
        end
    end
`else
    logic [NUM_OUT-1:0] route_oh;

    // One-hot port enable; forced to zero in reset so nothing leaks out.
    always_comb begin
        route_oh = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            route_oh[k] = ARESETn && in_range && (route == SEL_W'(k));
        end
    end

    assign s_ready = ARESETn & (in_range ? |(m_ready & route_oh) : 1'b1);

    always_comb begin
        m_valid = '0;
        m_data  = '0;
        m_last  = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            m_valid[k] = route_oh[k] & s_valid;
            if (route_oh[k]) begin
                m_data[k*DATA_W +: DATA_W] = s_data;
                m_last[k]                  = s_last;
            end
        end
    end
`endif

endmodule
